// File: rtl/stir_heat_ctrl.sv
// stir_heat_ctrl: soft-start motor PWM plus hysteresis heater control.
// Optional macro OVERTEMP_LOCK_EN adds an over-temperature lockout state.
//
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   en_i                run enable (level)
//   temp_i/temp_valid_i filtered temperature and its one-cycle strobe
//   setpoint_i          heater target, 0 disables the heater
//   vel_level_i         requested speed level (clamped to LEVELS-1)
//   motor_o, heater_o   actuator drives
//   duty_o              applied motor duty
//   state_o             0 IDLE, 1 RAMP, 2 RUN, 3 FAULT
//   fault_o             over-temperature lockout active
module stir_heat_ctrl #(
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned TEMP_W    = 8,
    parameter int unsigned LEVELS    = 8,
    parameter int unsigned PRESC     = 390,
    parameter int unsigned RAMP_STEP = 4,
    parameter int unsigned HYST      = 2,
    parameter int unsigned TEMP_MAX  = 120
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [TEMP_W-1:0] temp_i,
    input  logic              temp_valid_i,
    input  logic [TEMP_W-1:0] setpoint_i,
    input  logic [3:0]        vel_level_i,
    output logic              motor_o,
    output logic              heater_o,
    output logic [PWM_W-1:0]  duty_o,
    output logic [1:0]        state_o,
    output logic              fault_o
);

    localparam int unsigned MAXD  = (2 ** PWM_W) - 1;
    localparam int unsigned STEP  = MAXD / (LEVELS - 1);
    localparam int unsigned PRE_W = (PRESC > 1) ? $clog2(PRESC) : 1;

`ifdef OVERTEMP_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t            state;
    logic [PRE_W-1:0]  pre;
    logic [PWM_W-1:0]  cnt;
    logic [PWM_W-1:0]  duty;
    logic              tick;
    logic              per_start;

    logic [3:0]        lvl;
    logic [31:0]       prod;
    logic [PWM_W-1:0]  target;
    logic [PWM_W-1:0]  nd;

    logic signed [TEMP_W+1:0] lo_s;
    logic signed [TEMP_W+1:0] temp_s;
    logic [TEMP_W:0]          hi_sum;
    logic                     heat_nx;
    logic                     overtemp;

    // Prescaler and PWM counter run free in every state.
    assign tick      = (pre == PRE_W'(PRESC - 1));
    assign per_start = tick && (&cnt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre <= '0;
            cnt <= '0;
        end else if (tick) begin
            pre <= '0;
            cnt <= cnt + PWM_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Level clamp and target duty; the top level is pinned to full scale.
    always_comb begin
        lvl = vel_level_i;
        if (32'(vel_level_i) >= LEVELS)
            lvl = 4'(LEVELS - 1);
        prod = 32'(lvl) * STEP;
        if (lvl == 4'(LEVELS - 1))
            target = PWM_W'(MAXD);
        else
            target = prod[PWM_W-1:0];
    end

    // One saturating ramp step toward the target.
    always_comb begin
        nd = duty;
        if (target > duty) begin
            if (32'(target - duty) <= RAMP_STEP)
                nd = target;
            else
                nd = duty + PWM_W'(RAMP_STEP);
        end else if (target < duty) begin
            if (32'(duty - target) <= RAMP_STEP)
                nd = target;
            else
                nd = duty - PWM_W'(RAMP_STEP);
        end
    end

    // Hysteresis band; the low edge is signed so small setpoints
    // cannot wrap, the high edge gets one extra bit.
    always_comb begin
        lo_s    = $signed({2'b00, setpoint_i})
                - $signed((TEMP_W + 2)'(HYST));
        temp_s  = $signed({2'b00, temp_i});
        hi_sum  = {1'b0, setpoint_i} + (TEMP_W + 1)'(HYST);
        heat_nx = heater_o;
        if (setpoint_i == '0)
            heat_nx = 1'b0;
        else if (temp_s < lo_s)
            heat_nx = 1'b1;
        else if ({1'b0, temp_i} >= hi_sum)
            heat_nx = 1'b0;
    end

    assign overtemp = LOCK_EN && temp_valid_i
                   && (32'(temp_i) >= TEMP_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            duty     <= '0;
            heater_o <= 1'b0;
        end else if (!en_i) begin
            state    <= IDLE;
            duty     <= '0;
            heater_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= RAMP;
                end
                RAMP, RUN: begin
                    if (overtemp) begin
                        state    <= FAULT;
                        heater_o <= 1'b0;
                    end else begin
                        if (temp_valid_i)
                            heater_o <= heat_nx;
                        if (state == RAMP) begin
                            if (per_start) begin
                                duty <= nd;
                                if (nd == target)
                                    state <= RUN;
                            end else if (duty == target) begin
                                state <= RUN;
                            end
                        end else if (target != duty) begin
                            state <= RAMP;
                        end
                    end
                end
                FAULT: begin
                    heater_o <= 1'b0;
                end
            endcase
        end
    end

    // Output stage; a falling enable silences the motor together
    // with the duty clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            motor_o <= 1'b0;
        else
            motor_o <= en_i && (cnt < duty);
    end

    assign duty_o  = duty;
    assign state_o = state;

`ifdef OVERTEMP_LOCK_EN
    assign fault_o = (state == FAULT);
`else
    assign fault_o = 1'b0;
`endif

endmodule
